sysid_check_master: RTL and testbench
=====================================

# sysid_check_master

Avalon-MM read master that interrogates the system-ID slave at power-up or on request. It reads the 32-bit ID word (word address 0) and the 32-bit timestamp word (word address 1) and compares both against build-time expected values. It then reports pass/fail with an error code. It sits beside the Nios II boot logic and gates board bring-up when a stale or mismatched FPGA image is loaded.

## Interface
- EXPECTED_ID, 32'h0000_0000, expected value of word 0
- EXPECTED_TIMESTAMP, 32'h5850_4150, expected value of word 1
- TIMEOUT_CYCLES, 255, maximum waitrequest-stalled cycles per read (1..65535); used only when the timeout feature is compiled in
- clock  input  1  system clock; all logic rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to run a check; sampled in IDLE and DONE only
- avm_address  output  1  word address to sysid slave (0 = ID, 1 = timestamp)
- avm_read  output  1  read strobe
- avm_waitrequest  input  1  slave stall; read completes in the cycle it is low
- avm_readdata  input  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  level, high while in DONE
- pass  output  1  valid when done=1; 1 = both words matched
- err  output  2  valid when done=1; 0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
- id_value  output  32  captured word 0
- ts_value  output  32  captured word 1

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE:
  - start=1 -> RD_ID.
- RD_ID:
  - Drives avm_read=1, avm_address=0.
  - Address and read stay stable while avm_waitrequest=1.
  - On avm_waitrequest=0: capture avm_readdata into id_value, then -> RD_TS.
- RD_TS:
  - Same handshake as RD_ID with avm_address=1.
  - Capture into ts_value, then -> CHECK.
- CHECK:
  - One cycle; compares the captured words against the expected values.
  - err priority: ID mismatch (1) over timestamp mismatch (2).
  - pass = (err == 0). Then -> DONE.
- DONE:
  - done, pass and err are held.
  - start=1 -> RD_ID; done clears the next cycle, and id_value/ts_value are kept until overwritten.
- start is ignored in RD_ID, RD_TS and CHECK; it is not queued.
- avm_read is never asserted outside RD_ID/RD_TS. avm_address=0 when idle.
- Reset mid-read: avm_read drops the next cycle and the in-flight transfer is abandoned. The slave is combinational, so no response can arrive late.

## Timing
- Reset values: state IDLE; avm_read=0, avm_address=0, busy=0, done=0, pass=0, err=0, id_value=0, ts_value=0.
- All outputs are registered.
- With waitrequest held low, start sampled in cycle 0 gives:
  - cycle 1: read of address 0
  - cycle 2: read of address 1
  - cycle 3: CHECK
  - cycle 4: done=1 with pass/err valid
- Each stalled cycle (avm_waitrequest=1 during a read) adds exactly one cycle.
- busy=1 in cycles 1..3; busy=0 in the cycle done rises.

## Configuration
- Macro: SYSID_CHECK_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter clears on entry to each read state and increments each cycle the read is stalled.
  - When the counter equals TIMEOUT_CYCLES while still stalled, avm_read deasserts the next cycle and the block goes directly to DONE with pass=0, err=3.
  - Timeout takes priority over any compare result.
- Not defined: no counter; the master waits indefinitely on avm_waitrequest, and err=3 is never produced.

## Test plan
- Slave with no stalls returning 0x00000000 / 0x58504150, start pulse -> reads at addresses 0 then 1 in consecutive cycles; done=1 four cycles after start; pass=1, err=0, ts_value=0x58504150.
- Slave returns ID 0x00000001 and wrong timestamp 0x12345678 -> pass=0, err=1 (ID has priority), id_value=0x00000001.
- Waitrequest high for 3 cycles on each read, correct data -> avm_address/avm_read stable during stalls; done=1 ten cycles after start; pass=1.
- Timeout build with TIMEOUT_CYCLES=4 and waitrequest stuck high -> avm_read low after the timeout expires; done=1, pass=0, err=3. Non-timeout build with the same stimulus -> still busy after 1000 cycles.
- Reset asserted during a stalled RD_TS -> next cycle all outputs at reset values; a subsequent start completes normally with pass=1.
- start pulsed during RD_ID and again in DONE -> the first pulse is ignored; the second restarts the check, done drops for the run, and the outputs are re-evaluated.

Source files
------------

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and checks them against build-time values.
// Optional stall timeout compiled in with `define SYSID_CHECK_TIMEOUT_EN.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5850_4150,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t state;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] stall_cnt;
`endif

  // ID mismatch outranks timestamp mismatch
  function automatic logic [1:0] compare_err(input logic [31:0] id_w, input logic [31:0] ts_w);
    if (id_w != EXPECTED_ID)             return ERR_ID;
    else if (ts_w != EXPECTED_TIMESTAMP) return ERR_TS;
    else                                 return ERR_NONE;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err         <= ERR_NONE;
      id_value    <= '0;
      ts_value    <= '0;
`ifdef SYSID_CHECK_TIMEOUT_EN
      stall_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
`ifdef SYSID_CHECK_TIMEOUT_EN
            stall_cnt   <= '0;
`endif
          end
        end
        RD_ID, RD_TS: begin
          if (!avm_waitrequest) begin
            if (state == RD_ID) begin
              id_value    <= avm_readdata;
              state       <= RD_TS;
              avm_address <= 1'b1;
            end else begin
              ts_value    <= avm_readdata;
              state       <= CHECK;
              avm_read    <= 1'b0;
              avm_address <= 1'b0;
            end
`ifdef SYSID_CHECK_TIMEOUT_EN
            stall_cnt <= '0;
          end else if (stall_cnt == TIMEOUT_LIMIT) begin
            // Abandon the stalled read and report straight away
            state       <= DONE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            err         <= ERR_TIMEOUT;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
`endif
          end
        end
        CHECK: begin
          err   <= compare_err(id_value, ts_value);
          pass  <= (compare_err(id_value, ts_value) == ERR_NONE);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Scoreboard bench for sysid_check_master: directed runs push expected results, a monitor checks each done.
// Covers no-stall, mismatches, stalls, stuck slave, reset mid-read and restart from DONE.
module tb_sysid_check_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  sysid_check_master #(
    .EXPECTED_ID        (32'h0000_0000),
    .EXPECTED_TIMESTAMP (32'h5850_4150),
    .TIMEOUT_CYCLES     (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err             (err),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  // Combinational slave with a programmable number of stall cycles per read
  logic [31:0] id_word, ts_word;
  int          stall_id, stall_ts, scnt;
  logic        stuck;

  assign avm_readdata    = avm_address ? ts_word : id_word;
  assign avm_waitrequest = stuck | (avm_read && (scnt < (avm_address ? stall_ts : stall_id)));

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) scnt <= scnt + 1;
    else                             scnt <= 0;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        p;
    logic [1:0]  e;
    logic [31:0] id;
    logic [31:0] ts;
    logic        cd;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: result checks on each rising done, plus request stability across stalls
  logic done_q = 1'b0;
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_addr = 1'b0, prev_rst = 1'b1;
  always @(negedge clock) begin
    exp_t x;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        x = sb.pop_front();
        chk("pass", 32'(pass), 32'(x.p));
        chk("err", 32'(err), 32'(x.e));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("latency", 32'(cyc - x.t0), 32'(x.lat));
        if (x.cd) begin
          chk("id_value", id_value, x.id);
          chk("ts_value", ts_value, x.ts);
        end
      end
    end
    if (prev_rd && prev_wr && !prev_rst && !done) begin
      chk("stall_read_stable", 32'(avm_read), 32'd1);
      chk("stall_addr_stable", 32'(avm_address), 32'(prev_addr));
    end
    done_q    = done;
    prev_rd   = avm_read;
    prev_wr   = avm_waitrequest;
    prev_addr = avm_address;
    prev_rst  = reset;
  end

  task automatic issue(input logic p, input logic [1:0] e, input logic cd, input int lat);
    exp_t x;
    @(negedge clock);
    start = 1'b1;
    x.p = p; x.e = e; x.id = id_word; x.ts = ts_word; x.cd = cd; x.lat = lat; x.t0 = cyc;
    sb.push_back(x);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_address", 32'(avm_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);
  endtask

  task automatic run(input logic [31:0] idw, input logic [31:0] tsw, input int sid, input int sts,
                     input logic p, input logic [1:0] e, input int lat);
    id_word = idw; ts_word = tsw; stall_id = sid; stall_ts = sts;
    issue(p, e, 1'b1, lat);
    drain(100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stuck = 1'b0;
    stall_id = 0; stall_ts = 0;
    id_word = 32'h0000_0000; ts_word = 32'h5850_4150;
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b0;

    // Correct image, no stalls, with cycle-by-cycle bus checks
    issue(1'b1, 2'd0, 1'b1, 4);
    chk("c1_read", 32'(avm_read), 32'd1);
    chk("c1_addr", 32'(avm_address), 32'd0);
    chk("c1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("c2_read", 32'(avm_read), 32'd1);
    chk("c2_addr", 32'(avm_address), 32'd1);
    @(negedge clock);
    chk("c3_read", 32'(avm_read), 32'd0);
    chk("c3_busy", 32'(busy), 32'd1);
    chk("c3_done", 32'(done), 32'd0);
    drain(100);

    run(32'h0000_0001, 32'h1234_5678, 0, 0, 1'b0, 2'd1, 4);
    run(32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 1'b0, 2'd2, 4);
    run(32'h0000_0000, 32'h5850_4150, 3, 3, 1'b1, 2'd0, 10);
    run(32'h0000_0000, 32'h5850_4150, 1, 2, 1'b1, 2'd0, 7);

    // Slave stuck in waitrequest
    stuck = 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
    issue(1'b0, 2'd3, 1'b0, 6);
    drain(100);
    chk("timeout_read_low", 32'(avm_read), 32'd0);
    stuck = 1'b0;
`else
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (1000) @(negedge clock);
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_done", 32'(done), 32'd0);
    chk("stuck_read", 32'(avm_read), 32'd1);
    stuck = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values();
`endif

    // Reset during a stalled timestamp read
    id_word = 32'hA5A5_A5A5; stall_id = 0; stall_ts = 50;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("rts_addr", 32'(avm_address), 32'd1);
    chk("rts_read", 32'(avm_read), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values();
    run(32'h0000_0000, 32'h5850_4150, 0, 0, 1'b1, 2'd0, 4);

    // start repeated during RD_ID is dropped; start in DONE reruns the check
    id_word = 32'h0000_0000; stall_id = 2; stall_ts = 0;
    issue(1'b1, 2'd0, 1'b1, 6);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain(100);
    repeat (10) @(negedge clock);
    chk("done_held", 32'(done), 32'd1);
    chk("pass_held", 32'(pass), 32'd1);
    id_word = 32'h0000_0001; stall_id = 0;
    issue(1'b0, 2'd1, 1'b1, 4);
    chk("restart_done_low", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    drain(100);
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
